snitch_mem_arbiter: RTL

Two-port request arbiter placed directly upstream of the single-port Snitch tiny-tapeout memory. It merges the core's instruction-fetch port and data (LSU) port onto the memory's 10-bit word-addressed req/rsp interface, using round-robin arbitration. It checks range and alignment, generates local write acknowledgements (the memory returns no write response), and routes read data back to the requesting port. At most one transaction is in flight in the whole block.

---
 rtl/snitch_tt_pkg.sv | 31 +++
 rtl/snitch_rr_arb2.sv | 35 +++
 rtl/snitch_mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/snitch_tt_pkg.sv
// Shared types and constants for the Snitch tiny-tapeout memory front end.
package snitch_tt_pkg;

  localparam int unsigned AddrW    = 32;
  localparam int unsigned DataW    = 32;
  localparam int unsigned MemAddrW = 10;
  localparam int unsigned MemBytes = 4096;

  typedef logic [AddrW-1:0]    addr_t;
  typedef logic [DataW-1:0]    data_t;
  typedef logic [MemAddrW-1:0] mem_addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRsp,
    StResp
  } arb_state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_e;

  // Misaligned, beyond the memory, or a partial-word write (only full or empty strobes are legal).
  function automatic logic req_err(input addr_t addr, input logic write, input logic [3:0] strb);
    logic bad_strb;
    bad_strb = write && (strb != 4'hF) && (strb != 4'h0);
    return (addr[1:0] != 2'b00) || (addr >= addr_t'(MemBytes)) || bad_strb;
  endfunction

endpackage

// File: rtl/snitch_rr_arb2.sv
// Two-requester round-robin arbiter; the last grant only moves when the grant is taken.
module snitch_rr_arb2
  import snitch_tt_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       gnt_valid_o,
  output port_e      gnt_o
);

  port_e last_q, last_d;

  always_comb begin
    gnt_o = INSTR;
    unique case (req_i)
      2'b01:   gnt_o = INSTR;
      2'b10:   gnt_o = DATA;
      2'b11:   gnt_o = (last_q == DATA) ? INSTR : DATA;
      default: gnt_o = INSTR;
    endcase
    gnt_valid_o = |req_i;
    last_d      = (upd_i && gnt_valid_o) ? gnt_o : last_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= DATA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/snitch_mem_arbiter.sv
// Merges fetch and LSU ports onto the single-port word-addressed memory, one transaction at a time.
module snitch_mem_arbiter
  import snitch_tt_pkg::*;
#(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned MemAddrWidth = 10,
  parameter int unsigned DataWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AddrWidth-1:0]    instr_req_addr_i,
  input  logic                    instr_req_valid_i,
  output logic                    instr_req_ready_o,
  output logic [DataWidth-1:0]    instr_rsp_data_o,
  output logic                    instr_rsp_err_o,
  output logic                    instr_rsp_valid_o,
  input  logic                    instr_rsp_ready_i,
  input  logic [AddrWidth-1:0]    data_req_addr_i,
  input  logic [DataWidth-1:0]    data_req_data_i,
  input  logic                    data_req_write_i,
  input  logic [3:0]              data_req_strb_i,
  input  logic                    data_req_valid_i,
  output logic                    data_req_ready_o,
  output logic [DataWidth-1:0]    data_rsp_data_o,
  output logic                    data_rsp_err_o,
  output logic                    data_rsp_valid_o,
  input  logic                    data_rsp_ready_i,
  output logic [MemAddrWidth-1:0] mem_req_addr_o,
  output logic [DataWidth-1:0]    mem_req_data_o,
  output logic                    mem_req_write_o,
  output logic                    mem_req_wstrb_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  input  logic [DataWidth-1:0]    mem_rsp_data_i,
  input  logic                    mem_rsp_valid_i,
  output logic                    mem_rsp_ready_o
);

  arb_state_e state_q, state_d;
  port_e      port_q, port_d;
  logic [DataWidth-1:0] rsp_q, rsp_d;
  logic       err_q, err_d;

  logic [1:0] arb_req;
  logic       arb_upd;
  logic       gnt_valid;
  port_e      gnt;

  logic [AddrWidth-1:0] sel_addr;
  logic       sel_write;
  logic [3:0] sel_strb;
  logic       sel_err;
  logic       sel_noop;
  logic       accept;
  logic       resp_done;

  // A late memory response seen in idle is drained first, so no request shares its cycle.
  assign arb_req = (state_q == StIdle && !mem_rsp_valid_i) ?
                   {data_req_valid_i, instr_req_valid_i} : 2'b00;

  snitch_rr_arb2 u_rr_arb2 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (arb_req),
    .upd_i      (arb_upd),
    .gnt_valid_o(gnt_valid),
    .gnt_o      (gnt)
  );

  always_comb begin
    state_d           = state_q;
    port_d            = port_q;
    rsp_d             = rsp_q;
    err_d             = err_q;
    arb_upd           = 1'b0;
    accept            = 1'b0;
    instr_req_ready_o = 1'b0;
    data_req_ready_o  = 1'b0;
    mem_req_valid_o   = 1'b0;
    mem_req_addr_o    = '0;
    mem_req_data_o    = '0;
    mem_req_write_o   = 1'b0;
    mem_req_wstrb_o   = 1'b0;
    mem_rsp_ready_o   = 1'b0;

    sel_addr  = (gnt == DATA) ? data_req_addr_i : instr_req_addr_i;
    sel_write = (gnt == DATA) && data_req_write_i;
    sel_strb  = (gnt == DATA) ? data_req_strb_i : 4'hF;
    sel_err   = req_err(sel_addr, sel_write, sel_strb);
    sel_noop  = sel_write && (sel_strb == 4'h0);

    resp_done = (port_q == INSTR) ? instr_rsp_ready_i : data_rsp_ready_i;

    unique case (state_q)
      StIdle: begin
        mem_rsp_ready_o = mem_rsp_valid_i;
        if (gnt_valid) begin
          if (sel_err || sel_noop) begin
            accept = 1'b1;
          end else begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = sel_addr[MemAddrWidth+1:2];
            mem_req_write_o = sel_write;
            mem_req_wstrb_o = sel_write;
            mem_req_data_o  = sel_write ? data_req_data_i : '0;
            accept          = mem_req_ready_i;
          end
          instr_req_ready_o = (gnt == INSTR) && accept;
          data_req_ready_o  = (gnt == DATA) && accept;
          if (accept) begin
            arb_upd = 1'b1;
            port_d  = gnt;
            err_d   = sel_err;
            rsp_d   = '0;
            state_d = (sel_err || sel_write) ? StResp : StWaitRsp;
          end
        end
      end
      StWaitRsp: begin
        mem_rsp_ready_o = mem_rsp_valid_i;
        if (mem_rsp_valid_i) begin
          rsp_d   = mem_rsp_data_i;
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    instr_rsp_valid_o = (state_q == StResp) && (port_q == INSTR);
    data_rsp_valid_o  = (state_q == StResp) && (port_q == DATA);
    instr_rsp_data_o  = instr_rsp_valid_o ? rsp_q : '0;
    instr_rsp_err_o   = instr_rsp_valid_o && err_q;
    data_rsp_data_o   = data_rsp_valid_o ? rsp_q : '0;
    data_rsp_err_o    = data_rsp_valid_o && err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      port_q  <= INSTR;
      rsp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
    end
  end

endmodule
